// File: rtl/bcd_updown_cntr.sv
// Synchronous multi-digit BCD up/down counter with load, clear, wrap/saturate ends
// and carry/overflow reporting. All digits are clocked together.
module bcd_updown_cntr #(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int ND = int'(DIGITS);
  localparam int W  = 4 * ND;

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         ovf_q, ovf_d;
  logic         load_err_q, load_err_d;

  logic         all9, all0;
  logic [W-1:0] load_san;
  logic         load_bad;
  logic [W-1:0] stepped;
  logic         chain;
  logic [3:0]   digit;

  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (count_q[4*i +: 4] != 4'd9) all9 = 1'b0;
      if (count_q[4*i +: 4] != 4'd0) all0 = 1'b0;
    end
  end

  assign tc = up ? all9 : all0;

  always_comb begin
    load_san = '0;
    load_bad = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_san[4*i +: 4] = 4'd9;
        load_bad           = 1'b1;
      end else begin
        load_san[4*i +: 4] = load_val[4*i +: 4];
      end
    end
  end

  // Digit i steps only while every lower digit sits at its rollover value.
  always_comb begin
    stepped = count_q;
    chain   = 1'b1;
    digit   = 4'd0;
    for (int i = 0; i < ND; i++) begin
      digit = count_q[4*i +: 4];
      if (chain) begin
        if (up) stepped[4*i +: 4] = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
        else    stepped[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
      end
      chain = chain & (up ? (digit == 4'd9) : (digit == 4'd0));
    end
  end

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    ovf_d      = ovf_q;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d    = load_san;
      ovf_d      = 1'b0;
      load_err_d = load_bad;
    end else if (en) begin
      if (tc) begin
        ovf_d = 1'b1;
        if (WRAP) begin
          count_d = up ? '0 : {ND{4'd9}};
          wrap_d  = 1'b1;
        end
      end else begin
        count_d = stepped;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_cntr.sv
// Scoreboard bench: wrap and saturate instances driven together, checked against
// an integer-valued decimal model.
module tb_bcd_updown_cntr;

  localparam int D    = 4;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        rst, en, up, clr, load;
  logic [15:0] load_val;
  logic [15:0] count_w, count_s;
  logic        tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s, lerr_w, lerr_s;

  typedef struct {
    logic [15:0] cw;
    logic [15:0] cs;
    logic        ww, ws, ow, os, lw, ls;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   mv[2];
  bit   mo[2];

  bcd_updown_cntr #(.DIGITS(D), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(count_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w), .load_err(lerr_w)
  );

  bcd_updown_cntr #(.DIGITS(D), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .load_val(load_val),
    .count(count_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s), .load_err(lerr_s)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] b;
    int          t;
    t = v;
    for (int i = 0; i < D; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  task automatic compare();
    exp_t x;
    check_eq("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check_eq("count_w", count_w, x.cw);
      check_eq("count_s", count_s, x.cs);
      check_eq("wrap_w", wrap_w, x.ww);
      check_eq("wrap_s", wrap_s, x.ws);
      check_eq("ovf_w", ovf_w, x.ow);
      check_eq("ovf_s", ovf_s, x.os);
      check_eq("lerr_w", lerr_w, x.lw);
      check_eq("lerr_s", lerr_s, x.ls);
    end
  endtask

  task automatic drive(input bit e, input bit u, input bit c, input bit l,
                       input logic [15:0] lv);
    exp_t x;
    int   san;
    int   scale;
    bit   bad;
    bit   wr[2];
    @(negedge clk);
    en = e; up = u; clr = c; load = l; load_val = lv;
    #1;
    check_eq("tc_w", tc_w, u ? (mv[0] == MAXV) : (mv[0] == 0));
    check_eq("tc_s", tc_s, u ? (mv[1] == MAXV) : (mv[1] == 0));
    san   = 0;
    scale = 1;
    bad   = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (int'(lv[4*i +: 4]) > 9) begin
        san = san + 9 * scale;
        bad = 1'b1;
      end else begin
        san = san + int'(lv[4*i +: 4]) * scale;
      end
      scale = scale * 10;
    end
    for (int m = 0; m < 2; m++) begin
      wr[m] = 1'b0;
      if (c) begin
        mv[m] = 0;
        mo[m] = 1'b0;
      end else if (l) begin
        mv[m] = san;
        mo[m] = 1'b0;
      end else if (e) begin
        if (u) begin
          if (mv[m] == MAXV) begin
            mo[m] = 1'b1;
            if (m == 0) begin mv[m] = 0; wr[m] = 1'b1; end
          end else mv[m] = mv[m] + 1;
        end else begin
          if (mv[m] == 0) begin
            mo[m] = 1'b1;
            if (m == 0) begin mv[m] = MAXV; wr[m] = 1'b1; end
          end else mv[m] = mv[m] - 1;
        end
      end
    end
    x.cw = int2bcd(mv[0]);
    x.cs = int2bcd(mv[1]);
    x.ww = wr[0];
    x.ws = wr[1];
    x.ow = mo[0];
    x.os = mo[1];
    x.lw = !c && l && bad;
    x.ls = !c && l && bad;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    mv[0] = 0; mv[1] = 0; mo[0] = 1'b0; mo[1] = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_count_w", count_w, 0);
    check_eq("rst_count_s", count_s, 0);
    check_eq("rst_ovf", ovf_w, 0);
    check_eq("rst_wrap", wrap_w, 0);
    check_eq("rst_lerr", lerr_w, 0);
    check_eq("rst_tc_dn", tc_w, 1);
    up = 1'b1;
    #1;
    check_eq("rst_tc_up", tc_w, 0);
    rst = 1'b0;

    // Asynchronous reset between edges clears without a clock edge.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0457);
    @(negedge clk);
    en = 1'b1; load = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_w", count_w, 0);
    check_eq("async_rst_s", count_s, 0);
    #1 rst = 1'b0; en = 1'b0;
    mv[0] = 0; mv[1] = 0; mo[0] = 1'b0; mo[1] = 1'b0;

    repeat (12) drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    check_eq("count12", count_w, 16'h0012);
    check_eq("count12_tc", tc_w, 0);

    // Decimal carry and borrow.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0999);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    check_eq("carry", count_w, 16'h1000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("borrow", count_w, 16'h0999);

    // Upper boundary, then clear.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    check_eq("wrap_pulse", wrap_w, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    check_eq("clr_ovf", ovf_w, 0);

    // Lower boundary: wrap instance wraps to all-9s, saturate holds.
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("sat_hold", count_s, 16'h0000);
    check_eq("sat_ovf", ovf_s, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);

    // Invalid digit sanitising.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1A3F);
    check_eq("sanitise", count_w, 16'h1939);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);

    // Priority: clear over load and en; load over en; load masks boundary ovf.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0042);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0077);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0077);
    check_eq("load_over_en", count_w, 16'h0077);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h9999);
    check_eq("load_no_ovf", ovf_w, 0);

    // Direction change at the boundary takes effect on the same edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);

    for (int k = 0; k < 80; k++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
            (($urandom_range(0, 1) == 0) ? 16'h9997 : 16'($urandom)));
    end

    check_eq("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
